// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU sequencer: opcodes, control-word bit positions,
// the idle control word and the sequencer state encoding.
package cpu_pkg;

    localparam int CTRL_W = 15;

    // Control word bit positions, MSB first: Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo
    localparam int BIT_CP   = 14;
    localparam int BIT_EP   = 13;
    localparam int BIT_LP   = 12;
    localparam int BIT_NLMA = 11;
    localparam int BIT_NLMD = 10;
    localparam int BIT_NCE  = 9;
    localparam int BIT_NLR  = 8;
    localparam int BIT_NLI  = 7;
    localparam int BIT_NEI  = 6;
    localparam int BIT_NLA  = 5;
    localparam int BIT_EA   = 4;
    localparam int BIT_SUB  = 3;
    localparam int BIT_EU   = 2;
    localparam int BIT_NLB  = 1;
    localparam int BIT_NLO  = 0;

    localparam logic [CTRL_W-1:0] IDLE_WORD = 15'h0FE3;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_NOP = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seqState_e;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps opcode, T-state and flags to the control word
// and flags the last microstep of the instruction.
module microcode_rom import cpu_pkg::*; #(
    parameter int T_W       = 3,
    parameter int EARLY_END = 1
) (
    input  logic [3:0]        opcode,
    input  logic [T_W-1:0]    t_state,
    input  logic              cf,
    input  logic              zf,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last
);

    logic [T_W-1:0] lastStep;

    always_comb begin
        ctrl = IDLE_WORD;
        case (t_state)
            T_W'(0): begin
                ctrl[BIT_EP]   = 1'b1;
                ctrl[BIT_NLMA] = 1'b0;
            end
            T_W'(1): ctrl[BIT_CP] = 1'b1;
            T_W'(2): begin
                ctrl[BIT_NCE] = 1'b0;
                ctrl[BIT_NLI] = 1'b0;
            end
            T_W'(3): begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[BIT_NEI]  = 1'b0;
                        ctrl[BIT_NLMA] = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[BIT_NEI] = 1'b0;
                        ctrl[BIT_NLA] = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl[BIT_NEI] = 1'b0;
                        ctrl[BIT_LP]  = 1'b1;
                    end
                    OP_JC: if (cf) begin
                        ctrl[BIT_NEI] = 1'b0;
                        ctrl[BIT_LP]  = 1'b1;
                    end
                    OP_JZ: if (zf) begin
                        ctrl[BIT_NEI] = 1'b0;
                        ctrl[BIT_LP]  = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl[BIT_EA]  = 1'b1;
                        ctrl[BIT_NLO] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T_W'(4): begin
                case (opcode)
                    OP_LDA: begin
                        ctrl[BIT_NCE] = 1'b0;
                        ctrl[BIT_NLA] = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[BIT_NCE] = 1'b0;
                        ctrl[BIT_NLB] = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[BIT_EA]   = 1'b1;
                        ctrl[BIT_NLMD] = 1'b0;
                    end
                    default: ;
                endcase
            end
            T_W'(5): begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        ctrl[BIT_EU]  = 1'b1;
                        ctrl[BIT_NLA] = 1'b0;
                        ctrl[BIT_SUB] = (opcode == OP_SUB);
                    end
                    OP_STA: ctrl[BIT_NLR] = 1'b0;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // HLT always stops at T3; otherwise the final step depends on whether instructions are padded
    always_comb begin
        lastStep = T_W'(5);
        if (opcode == OP_HLT) begin
            lastStep = T_W'(3);
        end else if (EARLY_END != 0) begin
            case (opcode)
                OP_LDA:                                lastStep = T_W'(4);
                OP_ADD, OP_SUB, OP_STA:                lastStep = T_W'(5);
                OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:  lastStep = T_W'(3);
                default:                               lastStep = T_W'(2);
            endcase
        end
    end

    // ">=" also recovers from any out-of-range counter value
    assign last = (t_state >= lastStep);

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: IDLE/RUN/HALT control with a T-state counter that
// steps through the microcode ROM while running.
module cpu_sequencer import cpu_pkg::*; #(
    parameter int T_W       = 3,
    parameter int OPCODE_W  = 4,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    input  logic                run,
    input  logic                step,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [T_W-1:0]      t_state,
    output logic                instr_done,
    output logic                halted
);

    seqState_e         state_q, state_d;
    logic [T_W-1:0]    t_q, t_d;
    logic              step_q;
    logic              stepEdge;
    logic [3:0]        opLow;
    logic [CTRL_W-1:0] romCtrl;
    logic              romLast;

    assign opLow = opcode[3:0];

    generate
        if (OPCODE_W > 4) begin : gUpperOpcode
            logic unusedUpperOpcode;
            assign unusedUpperOpcode = ^opcode[OPCODE_W-1:4];
        end
    endgenerate

    microcode_rom #(
        .T_W       (T_W),
        .EARLY_END (EARLY_END)
    ) uRom (
        .opcode  (opLow),
        .t_state (t_q),
        .cf      (cf),
        .zf      (zf),
        .ctrl    (romCtrl),
        .last    (romLast)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            step_q  <= step;
        end
    end

    assign stepEdge = step & ~step_q;

    // A running instruction always completes; run is only consulted at its last step
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        ctrl       = IDLE_WORD;
        instr_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                t_d = '0;
                if (run || stepEdge) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ctrl       = romCtrl;
                instr_done = romLast;
                if (romLast) begin
                    t_d = '0;
                    if (opLow == OP_HLT) begin
                        state_d = ST_HALT;
                    end else if (!run) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            ST_HALT: t_d = '0;
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    assign t_state = t_q;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer: one variable-length instance
// and one padded (EARLY_END=0) instance sharing clock and reset.
module tb_cpu_sequencer;

    localparam logic [14:0] IDLE = 15'h0FE3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        cf, zf, run, step;
    logic [14:0] ctrl;
    logic [2:0]  t_state;
    logic        instr_done, halted;

    logic        runPad, stepPad;
    logic [14:0] padCtrl;
    logic [2:0]  padT;
    logic        padDone, padHalted;

    int errors = 0;
    int checks = 0;

    logic [14:0] expCtrl [0:5];

    cpu_sequencer #(.T_W(3), .OPCODE_W(4), .EARLY_END(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .cf         (cf),
        .zf         (zf),
        .run        (run),
        .step       (step),
        .ctrl       (ctrl),
        .t_state    (t_state),
        .instr_done (instr_done),
        .halted     (halted)
    );

    cpu_sequencer #(.T_W(3), .OPCODE_W(4), .EARLY_END(0)) dutPad (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .cf         (cf),
        .zf         (zf),
        .run        (runPad),
        .step       (stepPad),
        .ctrl       (padCtrl),
        .t_state    (padT),
        .instr_done (padDone),
        .halted     (padHalted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Fetch words are common to every instruction; only the execute words vary
    task automatic setExp(input logic [14:0] w3, input logic [14:0] w4, input logic [14:0] w5);
        expCtrl[0] = 15'h27E3;
        expCtrl[1] = 15'h4FE3;
        expCtrl[2] = 15'h0D63;
        expCtrl[3] = w3;
        expCtrl[4] = w4;
        expCtrl[5] = w5;
    endtask

    // Starts from a negedge in IDLE, runs one instruction and drops run at step dropAt
    task automatic applyStimulus(input string name, input logic [3:0] op, input logic cfIn,
                                 input logic zfIn, input int len, input int dropAt);
        opcode = op;
        cf     = cfIn;
        zf     = zfIn;
        run    = 1'b1;
        for (int s = 0; s < len; s++) begin
            @(negedge clk);
            checkOutput($sformatf("%s ctrl T%0d", name, s), 32'(ctrl), 32'(expCtrl[s]));
            checkOutput($sformatf("%s t_state T%0d", name, s), 32'(t_state), 32'(s));
            checkOutput($sformatf("%s done T%0d", name, s), 32'(instr_done), 32'(s == len - 1));
            if (s == dropAt) run = 1'b0;
        end
        @(negedge clk);
        checkOutput($sformatf("%s back to idle ctrl", name), 32'(ctrl), 32'(IDLE));
        checkOutput($sformatf("%s back to idle t", name), 32'(t_state), 32'd0);
    endtask

    initial begin
        logic [31:0] stepPat;
        int          runCycles;
        int          doneCount;
        int          notHalted;
        logic        sawNlr;

        rst_n   = 1'b1;
        opcode  = 4'h0;
        cf      = 1'b0;
        zf      = 1'b0;
        run     = 1'b0;
        step    = 1'b0;
        runPad  = 1'b0;
        stepPad = 1'b0;
        #1 rst_n = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset ctrl", 32'(ctrl), 32'(IDLE));
        checkOutput("reset t_state", 32'(t_state), 32'd0);
        checkOutput("reset halted", 32'(halted), 32'd0);
        checkOutput("reset done", 32'(instr_done), 32'd0);
        checkOutput("reset pad ctrl", 32'(padCtrl), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle without run", 32'(ctrl), 32'(IDLE));

        setExp(15'h07A3, 15'h0DE1, 15'h0FC7);
        applyStimulus("ADD", 4'h1, 1'b0, 1'b0, 6, 5);
        setExp(15'h07A3, 15'h0DE1, 15'h0FCF);
        applyStimulus("SUB run drop", 4'h2, 1'b0, 1'b0, 6, 1);
        setExp(15'h07A3, 15'h0DC3, IDLE);
        applyStimulus("LDA", 4'h0, 1'b0, 1'b0, 5, 4);
        setExp(15'h07A3, 15'h0BF3, 15'h0EE3);
        applyStimulus("STA", 4'h4, 1'b0, 1'b0, 6, 5);
        setExp(15'h0F83, IDLE, IDLE);
        applyStimulus("LDI", 4'h5, 1'b0, 1'b0, 4, 3);
        setExp(15'h1FA3, IDLE, IDLE);
        applyStimulus("JMP", 4'h6, 1'b0, 1'b0, 4, 3);
        applyStimulus("JZ taken", 4'h8, 1'b0, 1'b1, 4, 3);
        applyStimulus("JC taken", 4'h7, 1'b1, 1'b0, 4, 3);
        setExp(IDLE, IDLE, IDLE);
        applyStimulus("JZ not taken", 4'h8, 1'b1, 1'b0, 4, 3);
        applyStimulus("JC not taken", 4'h7, 1'b0, 1'b1, 4, 3);
        applyStimulus("NOP", 4'h3, 1'b0, 1'b0, 3, 2);
        applyStimulus("undefined", 4'hA, 1'b0, 1'b0, 3, 2);
        setExp(15'h0FF2, IDLE, IDLE);
        applyStimulus("OUT", 4'hE, 1'b0, 1'b0, 4, 3);

        // Not-taken jump followed directly by the next fetch
        opcode = 4'h8;
        zf     = 1'b0;
        run    = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("JZ b2b done T3", 32'(instr_done), 32'd1);
        @(negedge clk);
        checkOutput("JZ b2b next t", 32'(t_state), 32'd0);
        checkOutput("JZ b2b next ctrl", 32'(ctrl), 32'h27E3);
        run = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("JZ b2b second done", 32'(instr_done), 32'd1);
        @(negedge clk);
        checkOutput("JZ b2b idle", 32'(ctrl), 32'(IDLE));

        // Two step pulses; the second has an extra rising edge while running
        opcode    = 4'h5;
        stepPat   = 32'h0000_1403;
        runCycles = 0;
        doneCount = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (ctrl !== IDLE) runCycles++;
            if (instr_done) doneCount++;
            step = stepPat[c];
        end
        step = 1'b0;
        checkOutput("step run cycles", 32'(runCycles), 32'd8);
        checkOutput("step instr count", 32'(doneCount), 32'd2);
        checkOutput("step end ctrl", 32'(ctrl), 32'(IDLE));
        checkOutput("step end t", 32'(t_state), 32'd0);

        // Reset during T4 of STA must kill the instruction before nLr fires
        opcode = 4'h4;
        run    = 1'b1;
        sawNlr = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (ctrl[8] == 1'b0) sawNlr = 1'b1;
        end
        checkOutput("STA at T4 ctrl", 32'(ctrl), 32'h0BF3);
        #1 rst_n = 1'b0;
        run = 1'b0;
        #1;
        checkOutput("async reset ctrl", 32'(ctrl), 32'(IDLE));
        checkOutput("async reset t", 32'(t_state), 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (ctrl[8] == 1'b0) sawNlr = 1'b1;
        end
        checkOutput("STA no nLr", 32'(sawNlr), 32'd0);
        rst_n = 1'b1;

        // HLT, then run/step activity must not leave HALT
        opcode = 4'hF;
        run    = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("HLT done T3", 32'(instr_done), 32'd1);
        checkOutput("HLT T3 ctrl", 32'(ctrl), 32'(IDLE));
        checkOutput("HLT T3 not yet halted", 32'(halted), 32'd0);
        @(negedge clk);
        checkOutput("halted", 32'(halted), 32'd1);
        notHalted = 0;
        for (int i = 0; i < 20; i++) begin
            run  = i[0];
            step = ~i[0];
            @(negedge clk);
            if (!halted || ctrl !== IDLE || t_state !== 3'd0) notHalted++;
        end
        checkOutput("halt sticky", 32'(notHalted), 32'd0);
        run  = 1'b0;
        step = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("halt cleared by reset", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Padded instance: NOP takes six cycles, two back to back
        opcode = 4'h3;
        setExp(IDLE, IDLE, IDLE);
        runPad = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("pad ctrl c%0d", c), 32'(padCtrl), 32'(expCtrl[c % 6]));
            checkOutput($sformatf("pad t c%0d", c), 32'(padT), 32'(c % 6));
            checkOutput($sformatf("pad done c%0d", c), 32'(padDone), 32'((c % 6) == 5));
            if (c == 8) runPad = 1'b0;
        end
        @(negedge clk);
        checkOutput("pad idle ctrl", 32'(padCtrl), 32'(IDLE));
        checkOutput("pad idle t", 32'(padT), 32'd0);
        checkOutput("main stayed idle", 32'(ctrl), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
